// File: rtl/td4_pkg.sv
// td4_pkg: shared opcodes, ALU source encodings and sequencer states for the TD4 fetch/decode stage
package td4_pkg;
  localparam int N = 4;
  localparam logic [3:0] OP_ADD_A  = 4'h0;
  localparam logic [3:0] OP_MOV_AB = 4'h1;
  localparam logic [3:0] OP_IN_A   = 4'h2;
  localparam logic [3:0] OP_MOV_AI = 4'h3;
  localparam logic [3:0] OP_MOV_BA = 4'h4;
  localparam logic [3:0] OP_ADD_B  = 4'h5;
  localparam logic [3:0] OP_IN_B   = 4'h6;
  localparam logic [3:0] OP_MOV_BI = 4'h7;
  localparam logic [3:0] OP_OUT_B  = 4'h9;
  localparam logic [3:0] OP_OUT_I  = 4'hB;
  localparam logic [3:0] OP_JNC    = 4'hE;
  localparam logic [3:0] OP_JMP    = 4'hF;
  localparam logic [1:0] SRC_A    = 2'b00;
  localparam logic [1:0] SRC_B    = 2'b01;
  localparam logic [1:0] SRC_IN   = 2'b10;
  localparam logic [1:0] SRC_ZERO = 2'b11;
  typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_FAULT} state_t;
endpackage

// File: rtl/td4_decoder.sv
// td4_decoder: combinational opcode decode into active-low load strobes, ALU source and jump load
module td4_decoder
  import td4_pkg::*;
(
  input  logic [3:0] op,
  input  logic       c,
  output logic       ld_a,
  output logic       ld_b,
  output logic       ld_out,
  output logic       cs_pc,
  output logic [1:0] sel,
  output logic       illegal
);
  always_comb begin
    ld_a    = 1'b1;
    ld_b    = 1'b1;
    ld_out  = 1'b1;
    cs_pc   = 1'b1;
    sel     = SRC_ZERO;
    illegal = 1'b0;
    case (op)
      OP_ADD_A:  begin sel = SRC_A;    ld_a = 1'b0; end
      OP_MOV_AB: begin sel = SRC_B;    ld_a = 1'b0; end
      OP_IN_A:   begin sel = SRC_IN;   ld_a = 1'b0; end
      OP_MOV_AI: begin sel = SRC_ZERO; ld_a = 1'b0; end
      OP_MOV_BA: begin sel = SRC_A;    ld_b = 1'b0; end
      OP_ADD_B:  begin sel = SRC_B;    ld_b = 1'b0; end
      OP_IN_B:   begin sel = SRC_IN;   ld_b = 1'b0; end
      OP_MOV_BI: begin sel = SRC_ZERO; ld_b = 1'b0; end
      OP_OUT_B:  begin sel = SRC_B;    ld_out = 1'b0; end
      OP_OUT_I:  begin sel = SRC_ZERO; ld_out = 1'b0; end
      OP_JNC:    cs_pc = c;
      OP_JMP:    cs_pc = 1'b0;
      default:   illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: program memory, LOAD/RUN/FAULT control and carry flag feeding the program counter
module instruction_sequencer
  import td4_pkg::*;
(
  input  logic           clk,
  input  logic           clr,
  input  logic [N-1:0]   pc,
  input  logic           we,
  input  logic [N-1:0]   wa,
  input  logic [2*N-1:0] wd,
  input  logic           run,
  input  logic           cin,
  output logic           cs_pc,
  output logic [N-1:0]   im,
  output logic           ld_a,
  output logic           ld_b,
  output logic           ld_out,
  output logic [1:0]     sel,
  output logic           ill,
  output logic           rdy
);
  state_t         state, state_nx;
  logic           c;
  logic [2*N-1:0] mem [2**N];
  logic [2*N-1:0] instr;
  logic           run_st;
  logic           d_ld_a, d_ld_b, d_ld_out, d_cs_pc, d_ill;
  logic [1:0]     d_sel;

  assign instr  = mem[pc];
  assign run_st = state == ST_RUN;

  td4_decoder u_dec (
    .op      (instr[2*N-1:N]),
    .c       (c),
    .ld_a    (d_ld_a),
    .ld_b    (d_ld_b),
    .ld_out  (d_ld_out),
    .cs_pc   (d_cs_pc),
    .sel     (d_sel),
    .illegal (d_ill)
  );

  // program memory survives clr so a reset can re-run the downloaded program
  always_ff @(posedge clk)
    if (state == ST_LOAD && we) mem[wa] <= wd;

  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      state <= ST_LOAD;
      c     <= 1'b0;
      ill   <= 1'b0;
    end else begin
      state <= state_nx;
      if (run_st && !d_ill) c <= cin;
      if (run_st && d_ill) ill <= 1'b1;
    end

  always_comb begin
    state_nx = state;
    if (state == ST_LOAD && run && !we) state_nx = ST_RUN;
    if (run_st && d_ill) state_nx = ST_FAULT;
  end

  // outside RUN the counter is pinned: to 0 while loading, to itself after a fault
  always_comb begin
    cs_pc  = run_st ? d_cs_pc : 1'b0;
    im     = run_st ? instr[N-1:0] : (state == ST_FAULT ? pc : '0);
    ld_a   = run_st ? d_ld_a : 1'b1;
    ld_b   = run_st ? d_ld_b : 1'b1;
    ld_out = run_st ? d_ld_out : 1'b1;
    sel    = run_st ? d_sel : SRC_ZERO;
    rdy    = run_st;
  end
endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: random and directed programs checked cycle by cycle against a behavioural model
module tb_instruction_sequencer;
  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [3:0] pc;
  logic       we = 1'b0;
  logic [3:0] wa = '0;
  logic [7:0] wd = '0;
  logic       run = 1'b0;
  logic       cin = 1'b0;
  logic       cs_pc, ld_a, ld_b, ld_out, ill, rdy;
  logic [3:0] im;
  logic [1:0] sel;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [1:0] m_mode;
  logic       m_c, m_ill;
  logic [3:0] m_pc;
  logic [7:0] m_mem [16];

  instruction_sequencer dut (
    .clk(clk), .clr(clr), .pc(pc), .we(we), .wa(wa), .wd(wd), .run(run), .cin(cin),
    .cs_pc(cs_pc), .im(im), .ld_a(ld_a), .ld_b(ld_b), .ld_out(ld_out), .sel(sel),
    .ill(ill), .rdy(rdy)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge clr)
    if (clr) pc <= '0;
    else pc <= !cs_pc ? im : pc + 4'd1;

  function automatic logic legal_op(input logic [3:0] op);
    return op < 4'd8 || op == 4'd9 || op == 4'd11 || op >= 4'd14;
  endfunction

  // {rdy, ill, cs_pc, ld_a, ld_b, ld_out, sel, im}
  function automatic logic [11:0] expect_out();
    logic [7:0] w;
    logic [3:0] op;
    logic       cs, la, lb, lo, wr_reg;
    logic [1:0] s;
    if (m_mode == 2'd0) return {1'b0, m_ill, 1'b0, 3'b111, 2'b11, 4'h0};
    if (m_mode == 2'd2) return {1'b0, 1'b1, 1'b0, 3'b111, 2'b11, m_pc};
    w      = m_mem[m_pc];
    op     = w[7:4];
    wr_reg = op < 4'd8 || op == 4'd9 || op == 4'd11;
    cs     = op == 4'hF ? 1'b0 : (op == 4'hE ? m_c : 1'b1);
    la     = !(op < 4'd8 && !op[2]);
    lb     = !(op < 4'd8 && op[2]);
    lo     = !(op == 4'd9 || op == 4'd11);
    s      = wr_reg ? op[1:0] : 2'b11;
    return {1'b1, m_ill, cs, la, lb, lo, s, w[3:0]};
  endfunction

  function automatic logic [3:0] next_pc();
    logic [11:0] e;
    e = expect_out();
    return !e[9] ? e[3:0] : m_pc + 4'd1;
  endfunction

  always @(posedge clk or posedge clr)
    if (clr) begin
      m_mode <= 2'd0;
      m_c    <= 1'b0;
      m_ill  <= 1'b0;
      m_pc   <= '0;
    end else begin
      m_pc <= next_pc();
      if (m_mode == 2'd0) begin
        if (we) m_mem[wa] <= wd;
        if (run && !we) m_mode <= 2'd1;
      end else if (m_mode == 2'd1) begin
        if (!legal_op(m_mem[m_pc][7:4])) begin
          m_mode <= 2'd2;
          m_ill  <= 1'b1;
        end else m_c <= cin;
      end
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h want %0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " out"}, {20'd0, rdy, ill, cs_pc, ld_a, ld_b, ld_out, sel, im}, {20'd0, expect_out()});
    chk({tag, " pc"}, {28'd0, pc}, {28'd0, m_pc});
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #2;
    check_all(tag);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    we = 1'b1;
    wa = a;
    wd = d;
    step("write");
    we = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    #1;
    check_all("clr");
    clr = 1'b0;
  endtask

  task automatic start();
    run = 1'b1;
    step("start");
    run = 1'b0;
  endtask

  task automatic cycles(input int n, input logic c_fixed, input logic rnd);
    for (int i = 0; i < n; i++) begin
      cin = rnd ? 1'($urandom_range(0, 1)) : c_fixed;
      if (rnd) begin
        we = 1'($urandom_range(0, 1));
        wa = 4'($urandom);
        wd = 8'($urandom);
      end
      step("run");
    end
    we = 1'b0;
  endtask

  initial begin
    logic [3:0] op;
    int         guard;
    #12;
    clr = 1'b0;
    check_all("reset");
    for (int i = 0; i < 3; i++) step("idle");
    for (int i = 0; i < 16; i++) wr(4'(i), 8'h30);
    wr(4'd0, 8'h35);
    wr(4'd1, 8'hF0);
    start();
    cycles(5, 1'b0, 1'b0);
    do_clr();
    wr(4'd0, 8'h0F);
    wr(4'd1, 8'hE3);
    start();
    cycles(4, 1'b1, 1'b0);
    do_clr();
    start();
    cycles(4, 1'b0, 1'b0);
    do_clr();
    we = 1'b1;
    run = 1'b1;
    wa = 4'd2;
    wd = 8'h80;
    step("we_run");
    we = 1'b0;
    step("run_go");
    run = 1'b0;
    cycles(8, 1'b1, 1'b0);
    do_clr();
    wr(4'd2, 8'h30);
    start();
    guard = 0;
    while (m_pc != 4'd7 && guard < 20) begin
      cycles(1, 1'b1, 1'b0);
      guard++;
    end
    chk("reach_pc7", {28'd0, m_pc}, 32'd7);
    do_clr();
    start();
    cycles(4, 1'b1, 1'b0);
    for (int r = 0; r < 20; r++) begin
      do_clr();
      for (int i = 0; i < 16; i++) begin
        op = 4'($urandom);
        if (!legal_op(op) && $urandom_range(0, 3) != 0) op = 4'h3;
        wr(4'(i), {op, 4'($urandom)});
      end
      start();
      cycles(25, 1'b0, 1'b1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Fetch/decode stage directly downstream of `ProgramCounter`. It holds the 16×8 program memory, reads the word addressed by the counter's `Q`, and decodes it into register load strobes, a source-mux select and an immediate. It keeps the carry flag and drives the counter's `CS`/`D` inputs for jumps. A LOAD/RUN/FAULT state machine covers program download, execution and halting on an illegal opcode.

## Interface
- `N`, 4, address/immediate width; instruction word is 2N bits (upper N opcode, lower N immediate)
- `CLK`  in  1  system clock, rising edge
- `CLR`  in  1  reset, asynchronous, active-high
- `PC`  in  N  current program address (counter `Q`)
- `WE`  in  1  program-memory write strobe, honoured only in LOAD
- `WA`  in  N  write address
- `WD`  in  2N  write data
- `RUN`  in  1  request transition LOAD→RUN
- `CIN`  in  1  ALU carry-out of the current instruction
- `CS_PC`  out  1  active-low load to counter (counter `CS`)
- `IM`  out  N  immediate / jump target (counter `D`, ALU operand)
- `LD_A`, `LD_B`, `LD_OUT`  out  1 each  active-low register load enables
- `SEL`  out  2  ALU source: 00 A, 01 B, 10 IN port, 11 zero
- `ILL`  out  1  sticky illegal-opcode flag
- `RDY`  out  1  high in RUN

## Operation
- States: LOAD (reset state), RUN, FAULT.
- LOAD:
  - `WE`=1 writes `mem[WA]<=WD` at the clock edge.
  - Outputs: `CS_PC`=0, `IM`=0 (counter pinned at 0), all `LD_*`=1, `SEL`=11.
- LOAD→RUN on an edge with `RUN`=1 and `WE`=0. If `RUN` and `WE` are both high, the write occurs and the transition waits.
- RUN:
  - Instruction I=`mem[PC]`, op=I[2N-1:N], `IM`=I[N-1:0].
  - `WE` is ignored.
  - Decode:
    - 0000 ADD A,Im: SEL=00, LD_A=0
    - 0001 MOV A,B: SEL=01, LD_A=0
    - 0010 IN A: SEL=10, LD_A=0
    - 0011 MOV A,Im: SEL=11, LD_A=0
    - 0100 MOV B,A: SEL=00, LD_B=0
    - 0101 ADD B,Im: SEL=01, LD_B=0
    - 0110 IN B: SEL=10, LD_B=0
    - 0111 MOV B,Im: SEL=11, LD_B=0
    - 1001 OUT B: SEL=01, LD_OUT=0
    - 1011 OUT Im: SEL=11, LD_OUT=0
    - 1110 JNC Im: CS_PC=0 iff C=0
    - 1111 JMP Im: CS_PC=0
  - Unlisted outputs are inactive (`CS_PC`=1, `LD_*`=1, `SEL`=11).
- Carry flag C: in RUN, `C<=CIN` at every edge, for every legal opcode including MOV/JMP.
- Illegal opcodes 1000, 1010, 1100, 1101 seen in RUN:
  - all `LD_*` held 1 that cycle;
  - next edge enters FAULT and sets `ILL`=1.
- FAULT:
  - `CS_PC`=0, `IM`=`PC` (counter holds), `LD_*`=1, `SEL`=11, `RDY`=0.
  - Exit only via `CLR`.
- `CLR` (any time, including mid-run or in FAULT): state=LOAD, C=0, `ILL`=0. Program memory is not cleared.
- Address wrap: PC 15→0 is natural counter wrap; no special handling.

## Timing
- Memory read and decode are combinational from `PC`, state and C. Zero-cycle latency: outputs for address k are valid in the same cycle the counter shows k.
- Registered elements: state, C, `ILL`, memory (synchronous write).
- Reset values: state LOAD, C=0, `ILL`=0, `RDY`=0, `CS_PC`=0, `IM`=0, `LD_*`=1, `SEL`=11.
- Jump: counter loads `IM` at the edge ending the JMP/JNC cycle; the target instruction decodes in the next cycle.
- JNC tests the C value registered at the previous edge, i.e. the carry of the preceding instruction.
- First instruction executed is `mem[0]`, in the cycle after the LOAD→RUN edge.
- Write-then-run: a word written at edge t is readable from t+1.

## Structure
- Package `td4_pkg`:
  - opcode localparams (`OP_ADD_A` … `OP_JMP`);
  - `SEL` encodings `SRC_A`, `SRC_B`, `SRC_IN`, `SRC_ZERO`;
  - state encoding `ST_LOAD`, `ST_RUN`, `ST_FAULT`.
- Sub-module `td4_decoder`: purely combinational; inputs op and C, outputs `LD_A`/`LD_B`/`LD_OUT`/`CS_PC`/`SEL` and an illegal flag. The sequencer gates its outputs by state.

## Test plan
- Reset, then idle 3 cycles → `CS_PC`=0, `IM`=0, `LD_*`=1, `SEL`=11, `RDY`=0, `ILL`=0.
- Write mem[0]=8'h35, mem[1]=8'hF0, assert `RUN` with counter attached:
  - PC=0: `LD_A`=0, `SEL`=11, `IM`=5;
  - PC=1: `CS_PC`=0, `IM`=0;
  - PC returns to 0 next cycle.
- JNC: mem[0]=8'h0F (ADD A,F), mem[1]=8'hE3; force `CIN`=1 in cycle 0 → no jump, PC=2. Repeat with `CIN`=0 → PC=3.
- `WE`=1 and `RUN`=1 together → write lands, `RDY` stays 0. `RDY`=1 after next edge with `WE`=0.
- mem[2]=8'h80 → at PC=2 all `LD_*`=1. Next edge: `ILL`=1, state FAULT, PC held at 2 for 5 cycles.
- `CLR` pulse mid-RUN at PC=7 → asynchronous return to LOAD, C=0, `ILL`=0. Program intact: re-run executes mem[0] unchanged.
